mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_arbiter_rr_arbiter.sv | 35 +++
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter: FSM state encoding and the registered request.
// The request struct is sized for the widest supported configuration (ADDR/DATA up to 64 bits).
package mem_arb_pkg;

    localparam int MREQ_AW = 64;
    localparam int MREQ_DW = 64;
    localparam int MREQ_BW = MREQ_DW / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [MREQ_AW-1:0] a;
        logic               we;
        logic [MREQ_DW-1:0] d;
        logic [MREQ_BW-1:0] be;
    } mreq_t;

endpackage

// File: rtl/mem_arbiter_rr_arbiter.sv
// Round-robin grant selection: masked priority encoder over requests above the
// last granted index, falling back to the lowest request when the mask is empty.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic                 take,
    output logic                 gnt_vld,
    output logic [$clog2(N)-1:0] gnt_idx
);
    localparam int IW = $clog2(N);

    logic [IW-1:0] last_q;
    logic [N-1:0]  mask;

    always_comb begin
        for (int i = 0; i < N; i++) mask[i] = (i > int'(last_q));
    end

    always_comb begin
        gnt_vld = |req;
        gnt_idx = '0;
        for (int i = N - 1; i >= 0; i--) if (req[i]) gnt_idx = IW'(i);
        // a request above the pointer overrides the wrap-around choice
        for (int i = N - 1; i >= 0; i--) if (req[i] && mask[i]) gnt_idx = IW'(i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  last_q <= IW'(N - 1);
        else if (take && gnt_vld) last_q <= gnt_idx;
    end

endmodule

// File: rtl/mem_arbiter.sv
// N-port to single-memory arbiter, one transaction outstanding at a time.
// Define MEM_ARB_TIMEOUT_EN to enable the response watchdog and idle drain of late beats.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int N_PORTS        = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [N_PORTS-1:0][ADDR_WIDTH-1:0]     p_req_addr,
    input  logic [N_PORTS-1:0]                     p_req_we,
    input  logic [N_PORTS-1:0][DATA_WIDTH-1:0]     p_req_data,
    input  logic [N_PORTS-1:0][DATA_WIDTH/8-1:0]   p_req_be,
    input  logic [N_PORTS-1:0]                     p_req_valid,
    output logic [N_PORTS-1:0]                     p_req_ready,
    output logic [DATA_WIDTH-1:0]                  p_resp_data,
    output logic [N_PORTS-1:0]                     p_resp_valid,
    input  logic [N_PORTS-1:0]                     p_resp_ready,
    output logic [ADDR_WIDTH-1:0]                  mem_req_addr,
    output logic                                   mem_req_we,
    output logic [DATA_WIDTH-1:0]                  mem_req_data,
    output logic [DATA_WIDTH/8-1:0]                mem_req_be,
    output logic                                   mem_req_valid,
    input  logic                                   mem_req_ready,
    input  logic [DATA_WIDTH-1:0]                  mem_resp_data,
    input  logic                                   mem_resp_valid,
    output logic                                   mem_resp_ready,
    output logic                                   timeout_err
);
    localparam int IW = $clog2(N_PORTS);
    localparam int BW = DATA_WIDTH / 8;

    arb_state_e    state_q, state_d;
    mreq_t         req_q;
    logic [IW-1:0] owner_q;
    logic          gnt_vld;
    logic [IW-1:0] gnt_idx;
    logic          grant;
    logic          to_hit;

    assign grant = (state_q == IDLE) && gnt_vld;

    rr_arbiter #(.N(N_PORTS)) u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (p_req_valid),
        .take    (grant),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam bit DRAIN_EN = 1'b1;

    logic [CW-1:0] wd_q;

    // held at zero outside WAIT, so every WAIT entry starts from a clean count
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    wd_q <= '0;
        else if (state_q != WAIT)   wd_q <= '0;
        else if (!to_hit)           wd_q <= wd_q + CW'(1);
    end

    assign to_hit = (state_q == WAIT) && (wd_q == CW'(TIMEOUT_CYCLES));
`else
    localparam bit DRAIN_EN       = 1'b0;
    localparam int unused_timeout = TIMEOUT_CYCLES;

    assign to_hit = 1'b0;
`endif

    assign timeout_err = to_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q   <= '0;
            owner_q <= '0;
        end else if (grant) begin
            req_q.a  <= MREQ_AW'(p_req_addr[gnt_idx]);
            req_q.we <= p_req_we[gnt_idx];
            req_q.d  <= MREQ_DW'(p_req_data[gnt_idx]);
            req_q.be <= MREQ_BW'(p_req_be[gnt_idx]);
            owner_q  <= gnt_idx;
        end
    end

    assign mem_req_addr = req_q.a[ADDR_WIDTH-1:0];
    assign mem_req_we   = req_q.we;
    assign mem_req_data = req_q.d[DATA_WIDTH-1:0];
    assign mem_req_be   = req_q.be[BW-1:0];

    // upper struct bits stay zero at narrower configurations
    logic unused_req_bits;
    assign unused_req_bits = ^req_q;

    always_comb begin
        state_d        = state_q;
        p_req_ready    = '0;
        p_resp_valid   = '0;
        p_resp_data    = '0;
        mem_req_valid  = 1'b0;
        mem_resp_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                mem_resp_ready = DRAIN_EN && !gnt_vld;
                if (gnt_vld) begin
                    p_req_ready[gnt_idx] = 1'b1;
                    state_d              = ISSUE;
                end
            end
            ISSUE: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_d = WAIT;
            end
            WAIT: begin
                if (to_hit) begin
                    p_resp_valid[owner_q] = 1'b1;
                    state_d               = IDLE;
                end else begin
                    p_resp_data           = mem_resp_data;
                    p_resp_valid[owner_q] = mem_resp_valid;
                    mem_resp_ready        = p_resp_ready[owner_q];
                    if (mem_resp_valid && p_resp_ready[owner_q]) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // input-driven IDLE outputs must also read zero while reset is held
        if (rst) begin
            p_req_ready    = '0;
            mem_resp_ready = 1'b0;
        end
    end

endmodule
